// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM register: forwarding, ALU, iterative mul/div with HI/LO.
// Optional: define EX_OVF_SUPPRESS_EN to drop RegWrite on signed add/sub overflow.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] RegData1In,
    input  logic [DATA_W-1:0] RegData2In,
    input  logic [DATA_W-1:0] ExtendidoIn,
    input  logic [REG_W-1:0]  rtIn,
    input  logic [REG_W-1:0]  rdIn,
    input  logic [5:0]        ALUControlIn,
    input  logic              ALUSrcIn,
    input  logic              RegDstIn,
    input  logic [6:0]        CtrlIn,
    input  logic              HaltIn,
    input  logic [1:0]        ForwardA,
    input  logic [1:0]        ForwardB,
    input  logic [DATA_W-1:0] MemFwdData,
    input  logic [DATA_W-1:0] WbFwdData,
    output logic [DATA_W-1:0] AluResultOut,
    output logic [DATA_W-1:0] WriteDataOut,
    output logic [REG_W-1:0]  WriteRegOut,
    output logic [6:0]        CtrlOut,
    output logic              HaltOut,
    output logic              Stall
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, stateNext;
    logic [5:0]         cnt;
    logic [32:0]        accHi;
    logic [31:0]        accLo, divisor, dividend;
    logic [31:0]        hiReg, loReg;
    logic               isDiv, negQ, negR, divZero;

    logic [31:0]        opA, fwdB, opB, aluRes;
    logic [4:0]         shamt;
    logic               isMulDiv, sgn, ovf;
    logic [6:0]         ctrlNext;
    logic [31:0]        magA, magB;

    logic [32:0]        mulSum, stepHi, divSh, divHi;
    logic [33:0]        divDiff;
    logic               divOk;
    logic [31:0]        stepLo;
    logic [63:0]        prod, prodFix;
    logic [31:0]        quot, rem, hiNext, loNext;

    always_comb begin
        case (ForwardA)
            2'b01:   opA = WbFwdData;
            2'b10:   opA = MemFwdData;
            default: opA = RegData1In;
        endcase
        case (ForwardB)
            2'b01:   fwdB = WbFwdData;
            2'b10:   fwdB = MemFwdData;
            default: fwdB = RegData2In;
        endcase
        opB = ALUSrcIn ? ExtendidoIn : fwdB;
    end

    assign shamt    = ExtendidoIn[10:6];
    assign isMulDiv = (ALUControlIn[5:2] == 4'b0110);
    assign sgn      = ~ALUControlIn[0];

    always_comb begin
        aluRes = '0;
        case (ALUControlIn)
            6'h20, 6'h21: aluRes = opA + opB;
            6'h22, 6'h23: aluRes = opA - opB;
            6'h24: aluRes = opA & opB;
            6'h25: aluRes = opA | opB;
            6'h26: aluRes = opA ^ opB;
            6'h27: aluRes = ~(opA | opB);
            6'h2A: aluRes = {31'b0, $signed(opA) < $signed(opB)};
            6'h2B: aluRes = {31'b0, opA < opB};
            6'h00: aluRes = opB << shamt;
            6'h02: aluRes = opB >> shamt;
            6'h03: aluRes = $unsigned($signed(opB) >>> shamt);
            6'h04: aluRes = opB << opA[4:0];
            6'h06: aluRes = opB >> opA[4:0];
            6'h07: aluRes = $unsigned($signed(opB) >>> opA[4:0]);
            6'h0F: aluRes = {opB[15:0], 16'b0};
            6'h10: aluRes = hiReg;
            6'h12: aluRes = loReg;
            default: aluRes = '0;
        endcase
    end

`ifdef EX_OVF_SUPPRESS_EN
    logic [31:0] sumW, difW;
    logic        addOvf, subOvf;
    always_comb begin
        sumW   = opA + opB;
        difW   = opA - opB;
        addOvf = (opA[31] == opB[31]) & (sumW[31] != opA[31]);
        subOvf = (opA[31] != opB[31]) & (difW[31] != opA[31]);
        ovf    = ((ALUControlIn == 6'h20) & addOvf)
               | ((ALUControlIn == 6'h22) & subOvf);
    end
`else
    assign ovf = 1'b0;
`endif

    assign ctrlNext = ovf ? {1'b0, CtrlIn[5:0]} : CtrlIn;

    assign magA = (sgn & opA[31]) ? (~opA + 32'd1) : opA;
    assign magB = (sgn & opB[31]) ? (~opB + 32'd1) : opB;

    // One shift-add (mul) or restoring-subtract (div) step on the magnitudes
    always_comb begin
        mulSum  = accLo[0] ? (accHi + {1'b0, divisor}) : accHi;
        divSh   = {accHi[31:0], accLo[31]};
        divDiff = {1'b0, divSh} - {2'b0, divisor};
        divOk   = ~divDiff[33];
        divHi   = divOk ? divDiff[32:0] : divSh;
        if (isDiv) begin
            stepHi = divHi;
            stepLo = {accLo[30:0], divOk};
        end else begin
            stepHi = {1'b0, mulSum[32:1]};
            stepLo = {mulSum[0], accLo[31:1]};
        end
        prod    = {stepHi[31:0], stepLo};
        prodFix = negQ ? (~prod + 64'd1) : prod;
        quot    = negQ ? (~stepLo + 32'd1) : stepLo;
        rem     = negR ? (~stepHi[31:0] + 32'd1) : stepHi[31:0];
        if (!isDiv) begin
            hiNext = prodFix[63:32];
            loNext = prodFix[31:0];
        end else if (divZero) begin
            hiNext = dividend;
            loNext = 32'hFFFF_FFFF;
        end else begin
            hiNext = rem;
            loNext = quot;
        end
    end

    always_comb begin
        stateNext = state;
        Stall     = 1'b0;
        case (state)
            IDLE: begin
                Stall = isMulDiv;
                if (isMulDiv) stateNext = BUSY;
            end
            BUSY: begin
                Stall = 1'b1;
                if (cnt == 6'd1) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            accHi    <= '0;
            accLo    <= '0;
            divisor  <= '0;
            dividend <= '0;
            isDiv    <= 1'b0;
            negQ     <= 1'b0;
            negR     <= 1'b0;
            divZero  <= 1'b0;
            hiReg    <= '0;
            loReg    <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && isMulDiv) begin
                cnt      <= 6'd32;
                accHi    <= '0;
                accLo    <= magA;
                divisor  <= magB;
                dividend <= opA;
                isDiv    <= ALUControlIn[1];
                negQ     <= sgn & (opA[31] ^ opB[31]);
                negR     <= sgn & opA[31];
                divZero  <= (opB == 32'd0);
            end else if (state == BUSY) begin
                cnt   <= cnt - 6'd1;
                accHi <= stepHi;
                accLo <= stepLo;
                if (cnt == 6'd1) begin
                    hiReg <= hiNext;
                    loReg <= loNext;
                end
            end
        end
    end

    // A stalled cycle loads a bubble into EX/MEM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AluResultOut <= '0;
            WriteDataOut <= '0;
            WriteRegOut  <= '0;
            CtrlOut      <= '0;
            HaltOut      <= 1'b0;
        end else if (Stall) begin
            AluResultOut <= '0;
            WriteDataOut <= '0;
            WriteRegOut  <= '0;
            CtrlOut      <= '0;
            HaltOut      <= 1'b0;
        end else begin
            AluResultOut <= aluRes;
            WriteDataOut <= fwdB;
            WriteRegOut  <= RegDstIn ? rdIn : rtIn;
            CtrlOut      <= ctrlNext;
            HaltOut      <= HaltIn;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: vector table, mul/div sequences,
// reset abort, and randomized ALU traffic against a behavioural model.
module tb_ex_mem_stage;

    logic        clk, reset;
    logic [31:0] RegData1In, RegData2In, ExtendidoIn;
    logic [4:0]  rtIn, rdIn;
    logic [5:0]  ALUControlIn;
    logic        ALUSrcIn, RegDstIn;
    logic [6:0]  CtrlIn;
    logic        HaltIn;
    logic [1:0]  ForwardA, ForwardB;
    logic [31:0] MemFwdData, WbFwdData;
    logic [31:0] AluResultOut, WriteDataOut;
    logic [4:0]  WriteRegOut;
    logic [6:0]  CtrlOut;
    logic        HaltOut, Stall;

    int checks = 0;
    int failures = 0;
    logic [31:0] mHi = 0, mLo = 0;

    ex_mem_stage dut (
        .clk(clk), .reset(reset),
        .RegData1In(RegData1In), .RegData2In(RegData2In),
        .ExtendidoIn(ExtendidoIn), .rtIn(rtIn), .rdIn(rdIn),
        .ALUControlIn(ALUControlIn), .ALUSrcIn(ALUSrcIn),
        .RegDstIn(RegDstIn), .CtrlIn(CtrlIn), .HaltIn(HaltIn),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .MemFwdData(MemFwdData), .WbFwdData(WbFwdData),
        .AluResultOut(AluResultOut), .WriteDataOut(WriteDataOut),
        .WriteRegOut(WriteRegOut), .CtrlOut(CtrlOut),
        .HaltOut(HaltOut), .Stall(Stall)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  code;
        logic [1:0]  fA, fB;
        logic [31:0] r1, r2, ext, mem, wb;
        logic        src, dst;
        logic [4:0]  rt, rd;
        logic [6:0]  ctrl;
        logic [31:0] eRes, eWd;
        logic [4:0]  eReg;
        logic [6:0]  eCtrl;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic setNop();
        RegData1In = 0; RegData2In = 0; ExtendidoIn = 0;
        rtIn = 0; rdIn = 0; ALUControlIn = 0; ALUSrcIn = 0;
        RegDstIn = 0; CtrlIn = 0; HaltIn = 0;
        ForwardA = 0; ForwardB = 0; MemFwdData = 0; WbFwdData = 0;
    endtask

    function automatic logic ovfOf(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = (c == 6'h20) ? sa + sb : sa - sb;
        return (c == 6'h20 || c == 6'h22) && (r > 64'sd2147483647 || r < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] refAlu(input logic [5:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        case (c)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B: return (a < b) ? 32'd1 : 32'd0;
            6'h00: return b << sh;
            6'h02: return b >> sh;
            6'h03: return $unsigned($signed(b) >>> sh);
            6'h04: return b << a[4:0];
            6'h06: return b >> a[4:0];
            6'h07: return $unsigned($signed(b) >>> a[4:0]);
            6'h0F: return b * 32'h10000;
            6'h10: return mHi;
            6'h12: return mLo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic refMulDiv(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            6'h18: begin p = sa * sb; mHi = p[63:32]; mLo = p[31:0]; end
            6'h19: begin p = {32'b0, a} * {32'b0, b}; mHi = p[63:32]; mLo = p[31:0]; end
            6'h1A: begin
                if (b == 0) begin mHi = a; mLo = 32'hFFFFFFFF; end
                else begin q = sa / sb; r = sa % sb; mHi = r[31:0]; mLo = q[31:0]; end
            end
            default: begin
                if (b == 0) begin mHi = a; mLo = 32'hFFFFFFFF; end
                else begin mHi = a % b; mLo = a / b; end
            end
        endcase
    endtask

    task automatic readHiLo(input string nm);
        setNop();
        ALUControlIn = 6'h10; CtrlIn = 7'h40; RegDstIn = 1; rdIn = 5'd7;
        @(posedge clk); #1;
        chk({nm, "_mfhi"}, AluResultOut, mHi);
        ALUControlIn = 6'h12;
        @(posedge clk); #1;
        chk({nm, "_mflo"}, AluResultOut, mLo);
        setNop();
    endtask

    task automatic runMulDiv(input string nm, input logic [5:0] c,
                             input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        int bad = 0;
        setNop();
        ALUControlIn = c; RegData1In = a; RegData2In = b;
        CtrlIn = 7'h7F; HaltIn = 1; RegDstIn = 1; rdIn = 5'd5;
        #1;
        while (Stall && n < 40) begin
            n++;
            @(posedge clk); #1;
            if (CtrlOut[6] || CtrlOut[3] || HaltOut) bad++;
            setNop();
            #1;
        end
        chk({nm, "_stallcycles"}, n, 33);
        chk({nm, "_bubbles"}, bad, 0);
        refMulDiv(c, a, b);
        readHiLo(nm);
    endtask

    vec_t tbl[15];
    logic [5:0] codes[20] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04,
                              6'h06, 6'h07, 6'h0F, 6'h10, 6'h12, 6'h3E};

    initial begin
        logic [6:0] ovfAdd, ovfSub;
`ifdef EX_OVF_SUPPRESS_EN
        ovfAdd = 7'h08; ovfSub = 7'h07;
`else
        ovfAdd = 7'h48; ovfSub = 7'h47;
`endif
        tbl[0]  = '{6'h20, 2'b00, 2'b00, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 0, 1, 5'd2, 5'd3, 7'h48, 32'h80000000, 32'h1, 5'd3, ovfAdd};
        tbl[1]  = '{6'h21, 2'b10, 2'b00, 32'h9, 32'h55, 32'h3, 32'h5, 0, 1, 1, 5'd4, 5'd6, 7'h40, 32'h8, 32'h55, 5'd6, 7'h40};
        tbl[2]  = '{6'h03, 2'b00, 2'b00, 0, 32'h80000000, 32'h100, 0, 0, 0, 0, 5'd9, 5'd12, 7'h21, 32'hF8000000, 32'h80000000, 5'd9, 7'h21};
        tbl[3]  = '{6'h23, 2'b00, 2'b00, 32'h5, 32'h7, 0, 0, 0, 0, 1, 5'd0, 5'd1, 7'h40, 32'hFFFFFFFE, 32'h7, 5'd1, 7'h40};
        tbl[4]  = '{6'h2A, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0, 1, 5'd0, 5'd2, 7'h40, 32'h1, 32'h1, 5'd2, 7'h40};
        tbl[5]  = '{6'h2B, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0, 1, 5'd0, 5'd2, 7'h40, 32'h0, 32'h1, 5'd2, 7'h40};
        tbl[6]  = '{6'h27, 2'b00, 2'b00, 32'h0F0F0F0F, 32'h00FF00FF, 0, 0, 0, 0, 1, 5'd0, 5'd8, 7'h40, 32'hF000F000, 32'h00FF00FF, 5'd8, 7'h40};
        tbl[7]  = '{6'h0F, 2'b00, 2'b00, 0, 32'hABCD, 32'h1234, 0, 0, 1, 0, 5'd10, 5'd0, 7'h40, 32'h12340000, 32'hABCD, 5'd10, 7'h40};
        tbl[8]  = '{6'h06, 2'b01, 2'b00, 0, 32'hF0000000, 0, 0, 32'h24, 0, 1, 5'd0, 5'd11, 7'h40, 32'h0F000000, 32'hF0000000, 5'd11, 7'h40};
        tbl[9]  = '{6'h24, 2'b00, 2'b11, 32'hFFFF0000, 32'h12345678, 0, 32'hDEAD, 0, 0, 1, 5'd0, 5'd13, 7'h40, 32'h12340000, 32'h12345678, 5'd13, 7'h40};
        tbl[10] = '{6'h3F, 2'b00, 2'b00, 32'h1, 32'h2, 0, 0, 0, 0, 1, 5'd0, 5'd14, 7'h40, 32'h0, 32'h2, 5'd14, 7'h40};
        tbl[11] = '{6'h25, 2'b00, 2'b10, 32'h2, 32'hFF, 32'h1, 32'hA0, 0, 1, 0, 5'd15, 5'd0, 7'h1B, 32'h3, 32'hA0, 5'd15, 7'h1B};
        tbl[12] = '{6'h22, 2'b00, 2'b00, 32'h80000000, 32'h1, 0, 0, 0, 0, 1, 5'd0, 5'd16, 7'h47, 32'h7FFFFFFF, 32'h1, 5'd16, ovfSub};
        tbl[13] = '{6'h00, 2'b00, 2'b00, 0, 32'h3, 32'h7C0, 0, 0, 0, 1, 5'd0, 5'd17, 7'h40, 32'h80000000, 32'h3, 5'd17, 7'h40};
        tbl[14] = '{6'h07, 2'b00, 2'b00, 32'h21, 32'h80000000, 0, 0, 0, 0, 1, 5'd0, 5'd18, 7'h40, 32'hC0000000, 32'h80000000, 5'd18, 7'h40};

        // Reset with live inputs: nothing may be captured
        reset = 0;
        setNop();
        ALUControlIn = 6'h21; RegData1In = 32'h11; RegData2In = 32'h22;
        CtrlIn = 7'h7F; HaltIn = 1; RegDstIn = 1; rdIn = 5'd31;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res", AluResultOut, 0);
        chk("rst_wd", WriteDataOut, 0);
        chk("rst_reg", WriteRegOut, 0);
        chk("rst_ctrl", CtrlOut, 0);
        chk("rst_halt", HaltOut, 0);
        chk("rst_stall", Stall, 0);
        reset = 1;
        #1;
        readHiLo("rst");

        foreach (tbl[i]) begin
            setNop();
            ALUControlIn = tbl[i].code; ForwardA = tbl[i].fA; ForwardB = tbl[i].fB;
            RegData1In = tbl[i].r1; RegData2In = tbl[i].r2; ExtendidoIn = tbl[i].ext;
            MemFwdData = tbl[i].mem; WbFwdData = tbl[i].wb; ALUSrcIn = tbl[i].src;
            RegDstIn = tbl[i].dst; rtIn = tbl[i].rt; rdIn = tbl[i].rd;
            CtrlIn = tbl[i].ctrl; HaltIn = i[0];
            @(posedge clk); #1;
            chk($sformatf("vec%0d_res", i), AluResultOut, tbl[i].eRes);
            chk($sformatf("vec%0d_wd", i), WriteDataOut, tbl[i].eWd);
            chk($sformatf("vec%0d_reg", i), WriteRegOut, tbl[i].eReg);
            chk($sformatf("vec%0d_ctrl", i), CtrlOut, tbl[i].eCtrl);
            chk($sformatf("vec%0d_halt", i), HaltOut, i[0]);
        end

        runMulDiv("mult", 6'h18, 32'hFFFFFFFE, 32'h3);
        chk("mult_hi_ref", mHi, 32'hFFFFFFFF);
        chk("mult_lo_ref", mLo, 32'hFFFFFFFA);
        runMulDiv("div", 6'h1A, 32'hFFFFFFF9, 32'h2);
        chk("div_lo_ref", mLo, 32'hFFFFFFFD);
        runMulDiv("divu0", 6'h1B, 32'h12345678, 32'h0);
        runMulDiv("div0", 6'h1A, 32'h87654321, 32'h0);
        runMulDiv("divmin", 6'h1A, 32'h80000000, 32'hFFFFFFFF);
        runMulDiv("multu", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] ra, rb;
            logic [5:0]  rc;
            ra = $urandom; rb = $urandom;
            if (k == 2) rb = rb & 32'hF;
            rc = 6'h18 + 6'($urandom_range(0, 3));
            runMulDiv($sformatf("rmd%0d", k), rc, ra, rb);
        end

        // Reset pulsed mid-BUSY aborts the operation and clears HI/LO
        setNop();
        ALUControlIn = 6'h18; RegData1In = 32'h1234; RegData2In = 32'h5678;
        @(posedge clk); #1;
        setNop();
        repeat (10) @(posedge clk);
        #2;
        chk("abort_busy", Stall, 1);
        reset = 0;
        #1;
        chk("abort_stall", Stall, 0);
        chk("abort_res", AluResultOut, 0);
        chk("abort_ctrl", CtrlOut, 0);
        chk("abort_reg", WriteRegOut, 0);
        @(negedge clk);
        reset = 1;
        mHi = 0; mLo = 0;
        @(posedge clk); #1;
        chk("abort_idle", Stall, 0);
        readHiLo("abort");
        runMulDiv("multu45", 6'h19, 32'd4, 32'd5);
        chk("multu45_lo_ref", mLo, 32'd20);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a, b, fb, er;
            logic [6:0]  ec;
            setNop();
            ALUControlIn = codes[$urandom_range(0, 19)];
            ForwardA = 2'($urandom); ForwardB = 2'($urandom);
            RegData1In = $urandom; RegData2In = $urandom;
            ExtendidoIn = $urandom; MemFwdData = $urandom; WbFwdData = $urandom;
            if (k % 7 == 0) RegData1In = 32'h7FFFFFF0 + 32'($urandom_range(0, 31));
            ALUSrcIn = 1'($urandom); RegDstIn = 1'($urandom);
            rtIn = 5'($urandom); rdIn = 5'($urandom);
            CtrlIn = 7'($urandom); HaltIn = 1'($urandom);
            a = (ForwardA == 2'b01) ? WbFwdData : (ForwardA == 2'b10) ? MemFwdData : RegData1In;
            fb = (ForwardB == 2'b01) ? WbFwdData : (ForwardB == 2'b10) ? MemFwdData : RegData2In;
            b = ALUSrcIn ? ExtendidoIn : fb;
            er = refAlu(ALUControlIn, a, b, ExtendidoIn[10:6]);
            ec = CtrlIn;
`ifdef EX_OVF_SUPPRESS_EN
            if (ovfOf(ALUControlIn, a, b)) ec[6] = 1'b0;
`endif
            #1;
            if (Stall) begin
                failures++;
                $display("FAIL rnd%0d_stall got=1 exp=0", k);
            end
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_res_op%h", k, ALUControlIn), AluResultOut, er);
            chk($sformatf("rnd%0d_wd", k), WriteDataOut, fb);
            chk($sformatf("rnd%0d_reg", k), WriteRegOut, RegDstIn ? rdIn : rtIn);
            chk($sformatf("rnd%0d_ctrl", k), {HaltOut, CtrlOut}, {HaltIn, ec});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
